// File: rtl/btb_2way_if.sv
// btb_2way_if: fetch lookup, EX update, flush and perf-counter signals of the BTB.
interface btb_2way_if #(
  parameter int PERF_W = 32
);
  logic              read_en;
  logic [31:0]       read_pc;
  logic              read_hit;
  logic [33:0]       read_entry;
  logic              update_en;
  logic [31:0]       update_pc;
  logic [31:0]       update_target;
  logic [1:0]        update_type;
  logic              flush;
  logic [PERF_W-1:0] lookup_count;
  logic [PERF_W-1:0] hit_count;
  modport master (
    output read_en, read_pc, update_en, update_pc, update_target, update_type, flush,
    input  read_hit, read_entry, lookup_count, hit_count
  );
  modport slave (
    input  read_en, read_pc, update_en, update_pc, update_target, update_type, flush,
    output read_hit, read_entry, lookup_count, hit_count
  );
endinterface

// File: rtl/btb_2way.sv
// btb_2way: two-way set-associative branch target buffer with per-set LRU and
// saturating lookup/hit counters; combinational read, registered update.
module btb_2way #(
  parameter int S_INDEX = 4,
  parameter int PERF_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  btb_2way_if.slave        bus
);
  localparam int SETS  = 1 << S_INDEX;
  localparam int TAG_W = 32 - S_INDEX - 2;
  logic [SETS-1:0][1:0] valid_q, valid_d;
  logic [SETS-1:0]      lru_q, lru_d;
  logic [PERF_W-1:0]    lookup_q, lookup_d, hit_q, hit_d;
  logic [TAG_W-1:0]     tag_q   [2][SETS];
  logic [33:0]          entry_q [2][SETS];
  logic [S_INDEX-1:0]   r_idx, u_idx;
  logic [TAG_W-1:0]     r_tag, u_tag;
  logic                 hit0, hit1, m0, m1, u_way, wr;
  assign r_idx = bus.read_pc[S_INDEX+1:2];
  assign r_tag = bus.read_pc[31:S_INDEX+2];
  assign u_idx = bus.update_pc[S_INDEX+1:2];
  assign u_tag = bus.update_pc[31:S_INDEX+2];
  assign hit0  = valid_q[r_idx][0] && tag_q[0][r_idx] == r_tag;
  assign hit1  = valid_q[r_idx][1] && tag_q[1][r_idx] == r_tag;
  assign m0    = valid_q[u_idx][0] && tag_q[0][u_idx] == u_tag;
  assign m1    = valid_q[u_idx][1] && tag_q[1][u_idx] == u_tag;
  // Victim: matching way, then first invalid way, then LRU.
  assign u_way = m0 ? 1'b0 : m1 ? 1'b1 : !valid_q[u_idx][0] ? 1'b0 :
                 !valid_q[u_idx][1] ? 1'b1 : lru_q[u_idx];
  assign wr    = bus.update_en && !bus.flush;
  assign bus.read_hit     = hit0 || hit1;
  assign bus.read_entry   = hit0 ? entry_q[0][r_idx] : hit1 ? entry_q[1][r_idx] : '0;
  assign bus.lookup_count = lookup_q;
  assign bus.hit_count    = hit_q;
  always_comb begin
    valid_d  = valid_q;
    lru_d    = lru_q;
    if (bus.read_en && bus.read_hit) lru_d[r_idx] = hit0;
    if (wr) begin
      valid_d[u_idx][u_way] = 1'b1;
      lru_d[u_idx]          = ~u_way;
    end
    if (bus.flush) valid_d = '0;
    lookup_d = (bus.read_en && lookup_q != '1) ? lookup_q + PERF_W'(1) : lookup_q;
    hit_d    = (bus.read_en && bus.read_hit && hit_q != '1) ? hit_q + PERF_W'(1) : hit_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      lru_q    <= '0;
      lookup_q <= '0;
      hit_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      lru_q    <= lru_d;
      lookup_q <= lookup_d;
      hit_q    <= hit_d;
    end
  end
  // Tag/entry arrays need no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (wr) begin
      tag_q[u_way][u_idx]   <= u_tag;
      entry_q[u_way][u_idx] <= {bus.update_target, bus.update_type};
    end
  end
endmodule

// File: tb/tb_btb_2way.sv
// tb_btb_2way: directed vector table plus hand sequences for saturation and async reset.
module tb_btb_2way;
  localparam logic [1:0] BR = 2'b00, JAL = 2'b01, JALR = 2'b10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  btb_2way_if #(.PERF_W(4)) bus ();
  btb_2way #(.S_INDEX(4), .PERF_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic        ren;
    logic [31:0] rpc;
    logic        uen;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic [1:0]  utyp;
    logic        fl;
    logic        xhit;
    logic [33:0] xent;
    logic [3:0]  xlk;
    logic [3:0]  xhc;
  } vec_t;
  vec_t v[$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic ren, input logic [31:0] rpc, input logic uen,
                       input logic [31:0] upc, input logic [31:0] utgt,
                       input logic [1:0] utyp, input logic fl);
    bus.read_en = ren; bus.read_pc = rpc; bus.update_en = uen; bus.update_pc = upc;
    bus.update_target = utgt; bus.update_type = utyp; bus.flush = fl;
  endtask
  task automatic cyc(input logic ren, input logic [31:0] rpc, input logic uen,
                     input logic [31:0] upc, input logic [31:0] utgt,
                     input logic [1:0] utyp, input logic fl);
    drive(ren, rpc, uen, upc, utgt, utyp, fl);
    @(posedge clk); #1;
  endtask
  initial begin
    // Counters shown are the values before the clock edge of that row.
    v.push_back('{1, 32'h40,  0, 32'h0,   32'h0,   BR,   0, 0, 34'h0,             0,  0});
    v.push_back('{0, 32'h40,  1, 32'h40,  32'h100, BR,   0, 0, 34'h0,             1,  0});
    v.push_back('{1, 32'h40,  0, 32'h0,   32'h0,   BR,   0, 1, {32'h100, BR},     1,  0});
    v.push_back('{0, 32'h40,  1, 32'h440, 32'h300, JAL,  0, 1, {32'h100, BR},     2,  1});
    v.push_back('{0, 32'h40,  1, 32'h840, 32'h400, JALR, 0, 1, {32'h100, BR},     2,  1});
    v.push_back('{1, 32'h40,  0, 32'h0,   32'h0,   BR,   0, 0, 34'h0,             2,  1});
    v.push_back('{1, 32'h440, 0, 32'h0,   32'h0,   BR,   0, 1, {32'h300, JAL},    3,  1});
    v.push_back('{1, 32'h840, 0, 32'h0,   32'h0,   BR,   0, 1, {32'h400, JALR},   4,  2});
    v.push_back('{0, 32'h840, 0, 32'h0,   32'h0,   BR,   1, 1, {32'h400, JALR},   5,  3});
    v.push_back('{0, 32'h840, 1, 32'h40,  32'h100, BR,   0, 0, 34'h0,             5,  3});
    v.push_back('{0, 32'h40,  1, 32'h440, 32'h300, JAL,  0, 1, {32'h100, BR},     5,  3});
    v.push_back('{1, 32'h40,  0, 32'h0,   32'h0,   BR,   0, 1, {32'h100, BR},     5,  3});
    v.push_back('{0, 32'h440, 1, 32'h840, 32'h400, JALR, 0, 1, {32'h300, JAL},    6,  4});
    v.push_back('{1, 32'h440, 0, 32'h0,   32'h0,   BR,   0, 0, 34'h0,             6,  4});
    v.push_back('{1, 32'h40,  0, 32'h0,   32'h0,   BR,   0, 1, {32'h100, BR},     7,  4});
    v.push_back('{1, 32'h840, 0, 32'h0,   32'h0,   BR,   0, 1, {32'h400, JALR},   8,  5});
    v.push_back('{1, 32'h40,  1, 32'h40,  32'h200, JAL,  0, 1, {32'h100, BR},     9,  6});
    v.push_back('{1, 32'h40,  0, 32'h0,   32'h0,   BR,   0, 1, {32'h200, JAL},   10,  7});
    v.push_back('{1, 32'h840, 0, 32'h0,   32'h0,   BR,   0, 1, {32'h400, JALR},  11,  8});
    v.push_back('{0, 32'h40,  1, 32'h80,  32'h500, BR,   1, 1, {32'h200, JAL},   12,  9});
    v.push_back('{1, 32'h40,  0, 32'h0,   32'h0,   BR,   0, 0, 34'h0,            12,  9});
    v.push_back('{1, 32'h80,  0, 32'h0,   32'h0,   BR,   0, 0, 34'h0,            13,  9});
    v.push_back('{0, 32'h80,  0, 32'h0,   32'h0,   BR,   0, 0, 34'h0,            14,  9});
    drive(0, 32'h40, 0, 0, 0, BR, 0);
    #2;
    chk("reset_hit", 64'(bus.read_hit), 64'd0);
    chk("reset_entry", 64'(bus.read_entry), 64'd0);
    chk("reset_lookup", 64'(bus.lookup_count), 64'd0);
    chk("reset_hits", 64'(bus.hit_count), 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < v.size(); i++) begin
      drive(v[i].ren, v[i].rpc, v[i].uen, v[i].upc, v[i].utgt, v[i].utyp, v[i].fl);
      #2;
      chk($sformatf("vec%0d_hit", i), 64'(bus.read_hit), 64'(v[i].xhit));
      chk($sformatf("vec%0d_entry", i), 64'(bus.read_entry), 64'(v[i].xent));
      chk($sformatf("vec%0d_lookup", i), 64'(bus.lookup_count), 64'(v[i].xlk));
      chk($sformatf("vec%0d_hits", i), 64'(bus.hit_count), 64'(v[i].xhc));
      @(posedge clk); #1;
    end
    // Saturation from a fresh reset, plus an index-isolation check.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    cyc(0, 32'h0, 1, 32'h40, 32'h100, BR, 0);
    cyc(0, 32'h0, 1, 32'h44, 32'h600, JALR, 0);
    drive(0, 32'h48, 0, 0, 0, BR, 0);
    #1 chk("other_index_miss", 64'(bus.read_hit), 64'd0);
    drive(0, 32'h44, 0, 0, 0, BR, 0);
    #1 chk("index1_entry", 64'(bus.read_entry), 64'({32'h600, JALR}));
    for (int i = 0; i < 20; i++) cyc(1, 32'h40, 0, 0, 0, BR, 0);
    chk("sat_lookup", 64'(bus.lookup_count), 64'hF);
    chk("sat_hits", 64'(bus.hit_count), 64'hF);
    chk("sat_still_hit", 64'(bus.read_hit), 64'd1);
    // Asynchronous reset mid-cycle: outputs clear without a clock edge.
    drive(0, 32'h40, 0, 0, 0, BR, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_hit", 64'(bus.read_hit), 64'd0);
    chk("async_entry", 64'(bus.read_entry), 64'd0);
    chk("async_lookup", 64'(bus.lookup_count), 64'd0);
    chk("async_hits", 64'(bus.hit_count), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
